// File: rtl/m01_frame_seq_pkg.sv
// Shared types for the m01 frame sequencer: FSM encoding, row/col widths and
// the config sanity check used when a frame is started.
package m01_frame_seq_pkg;

  localparam int ROW_W = 11;
  localparam int COL_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_READ,
    S_DRAIN,
    S_WAIT,
    S_DONE
  } state_t;

  // A frame with no rows or no bytes per row has nothing to read.
  function automatic logic cfg_bad(input logic [ROW_W-1:0] rows,
                                   input logic [COL_W-1:0] wpr);
    return (rows == '0) || (wpr == '0);
  endfunction

endpackage

// File: rtl/m01_rowcol_cnt.sv
// Row/column position counter for a raster of rows x wpr bytes.
// 'last' flags the final position of the frame at the current count.
module m01_rowcol_cnt
  import m01_frame_seq_pkg::*;
(
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             adv,
  input  logic [ROW_W-1:0] rows,
  input  logic [COL_W-1:0] wpr,
  output logic [ROW_W-1:0] row,
  output logic             last
);

  logic [COL_W-1:0] col;
  logic             col_end;

  assign col_end = (col == wpr - COL_W'(1));
  assign last    = col_end && (row == rows - ROW_W'(1));

  always_ff @(posedge clk) begin
    if (!nrst || clr) begin
      row <= '0;
      col <= '0;
    end else if (adv) begin
      if (col_end) begin
        col <= '0;
        row <= row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/m01_frame_seq.sv
// Frame sequencer for the 8-pixel binary first-moment calculator: fetches a
// binary frame from memory, tags each byte with its row and feeds the calculator.
module m01_frame_seq
  import m01_frame_seq_pkg::*;
#(
  parameter int ADDR_W  = 20,
  parameter int TMO_W   = 8,
  parameter int TMO_CYC = 64
)(
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [10:0]       cfg_rows,
  input  logic [7:0]        cfg_wpr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [7:0]        mem_rdata,
  output logic              cnt_en,
  output logic [10:0]       vcount,
  output logic [7:0]        pix_data,
  output logic              rd_done,
  input  logic              calc_done,
  output logic              busy,
  output logic              frame_done,
  output logic              err_tmo,
  output logic              err_cfg
);

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [ROW_W-1:0]  rows_q;
  logic [COL_W-1:0]  wpr_q;
  logic [TMO_W-1:0]  tmo_cnt;

  logic             cnt_clr, iss_adv, ret_adv;
  logic [ROW_W-1:0] iss_row, ret_row;
  logic             iss_last, ret_last;

  // Return pipe: stage 1 carries the row tag, stage 2 the pixel byte.
  logic [2:1]       vld_pipe;
  logic [7:0]       s1_data;
  logic             s1_last, s2_last;

  assign cnt_clr = (state == S_CLEAR);
  assign iss_adv = (state == S_READ) && mem_gnt;
  assign ret_adv = ((state == S_READ) || (state == S_DRAIN)) && mem_rvalid;

  m01_rowcol_cnt u_iss (
    .clk  (clk),
    .nrst (nrst),
    .clr  (cnt_clr),
    .adv  (iss_adv),
    .rows (rows_q),
    .wpr  (wpr_q),
    .row  (iss_row),
    .last (iss_last)
  );

  m01_rowcol_cnt u_ret (
    .clk  (clk),
    .nrst (nrst),
    .clr  (cnt_clr),
    .adv  (ret_adv),
    .rows (rows_q),
    .wpr  (wpr_q),
    .row  (ret_row),
    .last (ret_last)
  );

  // Only the issue side's last flag matters; its row index is informational.
  logic unused_iss_row;
  assign unused_iss_row = ^iss_row;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      vld_pipe <= '0;
      s1_data  <= '0;
      s1_last  <= 1'b0;
      s2_last  <= 1'b0;
      vcount   <= '0;
      pix_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1], ret_adv};
      s1_data  <= mem_rdata;
      s1_last  <= ret_last;
      s2_last  <= s1_last;
      if (ret_adv) vcount <= ret_row;
      pix_data <= vld_pipe[1] ? s1_data : 8'h00;
    end
  end

  assign rd_done = vld_pipe[2] && s2_last;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state      <= S_IDLE;
      base_q     <= '0;
      rows_q     <= '0;
      wpr_q      <= '0;
      tmo_cnt    <= '0;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      cnt_en     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      err_tmo    <= 1'b0;
      err_cfg    <= 1'b0;
    end else begin
      cnt_en     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q  <= cfg_base;
            rows_q  <= cfg_rows;
            wpr_q   <= cfg_wpr;
            busy    <= 1'b1;
            err_tmo <= 1'b0;
            if (cfg_bad(cfg_rows, cfg_wpr)) begin
              err_cfg    <= 1'b1;
              frame_done <= 1'b1;
              state      <= S_DONE;
            end else begin
              err_cfg <= 1'b0;
              cnt_en  <= 1'b1;
              state   <= S_CLEAR;
            end
          end
        end
        S_CLEAR: begin
          mem_addr <= base_q;
          mem_rd   <= 1'b1;
          state    <= S_READ;
        end
        S_READ: begin
          if (mem_gnt) begin
            mem_addr <= mem_addr + ADDR_W'(1);
            if (iss_last) begin
              mem_rd <= 1'b0;
              state  <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (rd_done) begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (calc_done) begin
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else if (tmo_cnt == TMO_W'(TMO_CYC - 1)) begin
            err_tmo    <= 1'b1;
            frame_done <= 1'b1;
            state      <= S_DONE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_m01_frame_seq.sv
// Bench for m01_frame_seq: memory/calculator responder plus a stream-level
// reference (beat k -> row k/wpr, byte from address base+k) checked every cycle.
module tb_m01_frame_seq;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        start = 1'b0;
  logic [19:0] cfg_base = '0;
  logic [10:0] cfg_rows = '0;
  logic [7:0]  cfg_wpr = '0;
  logic        mem_rd;
  logic [19:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        cnt_en;
  logic [10:0] vcount;
  logic [7:0]  pix_data;
  logic        rd_done;
  logic        calc_done = 1'b0;
  logic        busy, frame_done, err_tmo, err_cfg;

  m01_frame_seq dut (
    .clk(clk), .nrst(nrst), .start(start), .cfg_base(cfg_base),
    .cfg_rows(cfg_rows), .cfg_wpr(cfg_wpr), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .cnt_en(cnt_en), .vcount(vcount),
    .pix_data(pix_data), .rd_done(rd_done), .calc_done(calc_done),
    .busy(busy), .frame_done(frame_done), .err_tmo(err_tmo), .err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] base;
    int rows; int wpr; int gmode; int lat; int cdly;
    bit ff; bit poke;
    int exp_n; bit exp_cfg; bit exp_tmo; int exp_gap;
  } vec_t;

  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Frame model state, written by the test sequence, consumed by the responder.
  bit          chk_en = 1'b0;
  int          cyc = 0;
  int          gmode = 0, lat = 1, cdly = 1, n_exp = 0, f_wpr = 1;
  logic [19:0] f_base = '0;
  bit          ff_data = 1'b0, stray = 1'b0, gtog = 1'b1;
  int          n_grant = 0, n_ret = 0, n_rdd = 0, n_fd = 0, n_cnt = 0, rd_n = 0, fd_n = 0;

  int          ret_due[$];
  logic [19:0] ret_adr[$];
  bit          pv[4], pl[4], vv[4];
  logic [7:0]  pb[4];
  logic [10:0] vr[4];
  logic [10:0] vc_hold = '0;
  bit          prev_wait = 1'b0, fd_prev = 1'b0, g;
  logic [19:0] prev_addr = '0, exp_a, a;
  int          slot;

  function automatic logic [7:0] dat(input logic [19:0] ad);
    return ff_data ? 8'hFF : (ad[7:0] ^ ad[15:8] ^ 8'h3C);
  endfunction

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!chk_en) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; calc_done = 1'b0;
      ret_due.delete(); ret_adr.delete();
      for (int i = 0; i < 4; i++) begin pv[i] = 1'b0; vv[i] = 1'b0; end
      vc_hold = vcount; prev_wait = 1'b0; fd_prev = 1'b0;
    end else begin
      slot = cyc % 4;
      if (vv[slot]) vc_hold = vr[slot];
      chk("pix_data", 32'(pix_data), pv[slot] ? 32'(pb[slot]) : 32'd0);
      chk("rd_done", 32'(rd_done), 32'(pv[slot] && pl[slot]));
      chk("vcount", 32'(vcount), 32'(vc_hold));
      pv[slot] = 1'b0; vv[slot] = 1'b0;
      if (fd_prev) chk("busy_drop", 32'(busy), 32'd0);
      fd_prev = frame_done;
      if (rd_done) begin n_rdd++; rd_n = cyc; end
      if (frame_done) begin n_fd++; fd_n = cyc; end
      if (cnt_en) n_cnt++;
      if (prev_wait) chk("addr_hold", 32'({mem_rd, mem_addr}), 32'({1'b1, prev_addr}));

      case (gmode)
        0:       g = 1'b1;
        1:       begin g = gtog; gtog = !gtog; end
        default: g = 1'($urandom_range(0, 1));
      endcase
      mem_gnt = g;
      if (mem_rd && g) begin
        if (n_grant >= n_exp) chk("over_issue", 32'(n_grant), 32'(n_exp));
        else begin
          exp_a = f_base + 20'(n_grant);
          chk("gnt_addr", 32'(mem_addr), 32'(exp_a));
          ret_due.push_back(cyc + lat);
          ret_adr.push_back(exp_a);
        end
        n_grant++;
      end
      prev_wait = mem_rd && !g;
      prev_addr = mem_addr;

      mem_rvalid = 1'b0;
      mem_rdata  = 8'($urandom);
      if (ret_due.size() > 0 && ret_due[0] <= cyc) begin
        a = ret_adr.pop_front();
        void'(ret_due.pop_front());
        mem_rvalid = 1'b1;
        mem_rdata  = dat(a);
        vv[(cyc + 1) % 4] = 1'b1;
        vr[(cyc + 1) % 4] = 11'(n_ret / f_wpr);
        pv[(cyc + 2) % 4] = 1'b1;
        pb[(cyc + 2) % 4] = dat(a);
        pl[(cyc + 2) % 4] = (n_ret == n_exp - 1);
        n_ret++;
      end else if (stray) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 8'hA5;
        stray      = 1'b0;
      end
      calc_done = (cdly > 0) && (n_rdd > 0) && (cyc == rd_n + cdly);
    end
  end

  task automatic chk_zero(input string nm);
    chk({nm, ":ctl"}, 32'({mem_rd, cnt_en, rd_done, busy, frame_done, err_tmo, err_cfg}), 32'd0);
    chk({nm, ":mem_addr"}, 32'(mem_addr), 32'd0);
    chk({nm, ":vcount"}, 32'(vcount), 32'd0);
    chk({nm, ":pix_data"}, 32'(pix_data), 32'd0);
  endtask

  task automatic begin_frame(input vec_t v, output int st);
    gmode = v.gmode; lat = v.lat; cdly = v.cdly; ff_data = v.ff; gtog = 1'b1;
    f_base = v.base; f_wpr = (v.wpr > 0) ? v.wpr : 1; n_exp = v.rows * v.wpr;
    n_grant = 0; n_ret = 0; n_rdd = 0; n_fd = 0; n_cnt = 0; rd_n = 0; fd_n = 0;
    cfg_base = v.base; cfg_rows = 11'(v.rows); cfg_wpr = 8'(v.wpr);
    start = 1'b1; st = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_frame(input vec_t v, input string nm);
    int st, budget;
    bit poked;
    begin_frame(v, st);
    chk({nm, ":busy"}, 32'(busy), 32'd1);
    chk({nm, ":err_tmo_clr"}, 32'(err_tmo), 32'd0);
    chk({nm, ":err_cfg_start"}, 32'(err_cfg), 32'(v.exp_cfg));
    budget = v.exp_n * (v.lat + 3) * 2 + 200;
    poked = 1'b0;
    for (int i = 0; i < budget && n_fd == 0; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (v.poke && !poked && n_grant >= 2) begin
        start = 1'b1; cfg_base = 20'hABCDE; cfg_rows = 11'd1; cfg_wpr = 8'd1; poked = 1'b1;
      end
    end
    start = 1'b0;
    if (n_fd == 0) chk({nm, ":frame_timeout"}, 32'd0, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    chk({nm, ":grants"}, 32'(n_grant), 32'(v.exp_n));
    chk({nm, ":beats"}, 32'(n_ret), 32'(v.exp_n));
    chk({nm, ":rd_done_cnt"}, 32'(n_rdd), 32'(v.exp_n > 0));
    chk({nm, ":cnt_en_cnt"}, 32'(n_cnt), 32'(!v.exp_cfg));
    chk({nm, ":frame_done_cnt"}, 32'(n_fd), 32'd1);
    chk({nm, ":err_cfg"}, 32'(err_cfg), 32'(v.exp_cfg));
    chk({nm, ":err_tmo"}, 32'(err_tmo), 32'(v.exp_tmo));
    chk({nm, ":busy_end"}, 32'(busy), 32'd0);
    chk({nm, ":done_gap"}, 32'(v.exp_cfg ? fd_n - st : fd_n - rd_n), 32'(v.exp_gap));
  endtask

  vec_t tbl[10];
  vec_t rv;
  int   st0;

  initial begin
    tbl[0] = '{20'h00100,    2,   3, 0, 1, 3, 1'b1, 1'b0,    6, 1'b0, 1'b0,  4};
    tbl[1] = '{20'h02000,    4,   2, 1, 3, 2, 1'b0, 1'b0,    8, 1'b0, 1'b0,  3};
    tbl[2] = '{20'h00300,    1,   2, 0, 2, 0, 1'b0, 1'b0,    2, 1'b0, 1'b1, 65};
    tbl[3] = '{20'h00400,    2,   2, 0, 1, 1, 1'b0, 1'b0,    4, 1'b0, 1'b0,  2};
    tbl[4] = '{20'h00500,    0,   3, 0, 1, 1, 1'b0, 1'b0,    0, 1'b1, 1'b0,  2};
    tbl[5] = '{20'h00600,    3,   0, 0, 1, 1, 1'b0, 1'b0,    0, 1'b1, 1'b0,  2};
    tbl[6] = '{20'hFFFFE,    2,   3, 2, 4, 5, 1'b0, 1'b0,    6, 1'b0, 1'b0,  6};
    tbl[7] = '{20'h00700,    3,   2, 0, 1, 2, 1'b0, 1'b1,    6, 1'b0, 1'b0,  3};
    tbl[8] = '{20'h01000, 2047,   1, 0, 1, 1, 1'b0, 1'b0, 2047, 1'b0, 1'b0,  2};
    tbl[9] = '{20'h00040,    1, 255, 2, 2, 4, 1'b0, 1'b0,  255, 1'b0, 1'b0,  5};

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    nrst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        stray = 1'b1;
        repeat (4) @(posedge clk);
        #1;
      end
      run_frame(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of READ, then a clean frame.
    rv = '{20'h08000, 3, 4, 0, 2, 2, 1'b0, 1'b0, 12, 1'b0, 1'b0, 3};
    begin_frame(rv, st0);
    for (int i = 0; i < 100 && n_grant < 3; i++) begin @(posedge clk); #1; end
    chk("rst_mid:in_read", 32'(mem_rd), 32'd1);
    nrst = 1'b0; chk_en = 1'b0;
    @(posedge clk); #1;
    chk_zero("rst_mid");
    nrst = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;
    run_frame(rv, "after_rst");

    for (int i = 0; i < 12; i++) begin
      rv.base    = 20'($urandom);
      rv.rows    = $urandom_range(1, 5);
      rv.wpr     = $urandom_range(1, 6);
      rv.gmode   = $urandom_range(0, 2);
      rv.lat     = $urandom_range(1, 4);
      rv.cdly    = $urandom_range(0, 6);
      rv.ff      = 1'b0;
      rv.poke    = ($urandom_range(0, 3) == 0);
      rv.exp_n   = rv.rows * rv.wpr;
      rv.exp_cfg = 1'b0;
      rv.exp_tmo = (rv.cdly == 0);
      rv.exp_gap = (rv.cdly == 0) ? 65 : rv.cdly + 1;
      run_frame(rv, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
